// File: rtl/wb_bridge_pkg.sv
// Shared types and widths for the Wishbone classic master bridge.
package wb_bridge_pkg;

    localparam int WB_AW = 32;
    localparam int WB_DW = 32;
    localparam int WB_SW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wbb_state_t;

    typedef struct packed {
        logic             we;
        logic [WB_AW-1:0] adr;
        logic [WB_DW-1:0] dat;
        logic [WB_SW-1:0] sel;
    } wb_cmd_t;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Counts stalled bus cycles; flags the last cycle allowed before abort.
module wb_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_master_bridge.sv
// Single-outstanding Wishbone classic initiator with a valid/ready
// command port, a valid/ready response port and a stall timeout.
module wb_master_bridge
    import wb_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [WB_AW-1:0] cmd_adr,
    input  logic [WB_DW-1:0] cmd_dat,
    input  logic [WB_SW-1:0] cmd_sel,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WB_DW-1:0] rsp_dat,
    output logic             rsp_err,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [WB_AW-1:0] wbm_adr_o,
    output logic [WB_DW-1:0] wbm_dat_o,
    output logic [WB_SW-1:0] wbm_sel_o,
    input  logic             wbm_ack_i,
    input  logic [WB_DW-1:0] wbm_dat_i
);

    wbb_state_t       state_q, state_d;
    wb_cmd_t          cmd_q, cmd_d;
    logic [WB_DW-1:0] rsp_dat_q, rsp_dat_d;
    logic             rsp_err_q, rsp_err_d;
    logic             ctr_clr;
    logic             ctr_en;
    logic             expired;

    wb_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_ctr (
        .clk_i  (wb_clk_i),
        .rst_i  (wb_rst_i),
        .clr    (ctr_clr),
        .en     (ctr_en),
        .expired(expired)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (cmd_valid) state_d = BUS;
            BUS:  if (wbm_ack_i || expired) state_d = RESP;
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        wbm_cyc_o = 1'b0;
        wbm_stb_o = 1'b0;
        rsp_valid = 1'b0;
        unique case (state_q)
            IDLE: cmd_ready = 1'b1;
            BUS: begin
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
            end
            RESP: rsp_valid = 1'b1;
            default: cmd_ready = 1'b0;
        endcase
    end

    // Ack wins over timeout when both land on the same cycle.
    always_comb begin
        cmd_d     = cmd_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;
        if (state_q == IDLE && cmd_valid) begin
            cmd_d.we  = cmd_we;
            cmd_d.adr = cmd_adr;
            cmd_d.dat = cmd_dat;
            cmd_d.sel = cmd_sel;
        end
        if (state_q == BUS) begin
            if (wbm_ack_i) begin
                rsp_dat_d = cmd_q.we ? '0 : wbm_dat_i;
                rsp_err_d = 1'b0;
            end else if (expired) begin
                rsp_dat_d = '0;
                rsp_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cmd_q     <= '0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            cmd_q     <= cmd_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign ctr_clr   = (state_q == IDLE);
    assign ctr_en    = (state_q == BUS) && !wbm_ack_i;

    assign wbm_we_o  = cmd_q.we;
    assign wbm_adr_o = cmd_q.adr;
    assign wbm_dat_o = cmd_q.dat;
    assign wbm_sel_o = cmd_q.sel;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed bench for wb_master_bridge: vector table plus corner sequences.
module tb_wb_master_bridge;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_ack_i = 1'b0;
    logic [31:0] wbm_dat_i = '0;

    int n_pass = 0;
    int n_total = 0;

    wb_master_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_adr  (cmd_adr),
        .cmd_dat  (cmd_dat),
        .cmd_sel  (cmd_sel),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_dat  (rsp_dat),
        .rsp_err  (rsp_err),
        .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o),
        .wbm_we_o (wbm_we_o),
        .wbm_adr_o(wbm_adr_o),
        .wbm_dat_o(wbm_dat_o),
        .wbm_sel_o(wbm_sel_o),
        .wbm_ack_i(wbm_ack_i),
        .wbm_dat_i(wbm_dat_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          waits;
        logic [31:0] rdata;
        logic        exp_err;
        logic [31:0] exp_dat;
        int          exp_stb;
        int          exp_lat;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Drive a command at a falling edge and run the slave until rsp_valid.
    task automatic issue(input vec_t v, output int stb_cnt, output int lat);
        int got;
        chk("cmd_ready_before", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_we    = v.we;
        cmd_adr   = v.adr;
        cmd_dat   = v.dat;
        cmd_sel   = v.sel;
        wbm_dat_i = v.rdata;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("cyc_c1", 32'(wbm_cyc_o), 32'd1);
        chk("stb_c1", 32'(wbm_stb_o), 32'd1);
        chk("we_c1", 32'(wbm_we_o), 32'(v.we));
        chk("adr_c1", wbm_adr_o, v.adr);
        chk("dat_c1", wbm_dat_o, v.dat);
        chk("sel_c1", 32'(wbm_sel_o), 32'(v.sel));
        stb_cnt = 0;
        lat = 0;
        got = 0;
        for (int k = 0; k < 60 && got == 0; k++) begin
            if (rsp_valid) begin
                got = 1;
                lat = k + 1;
            end else begin
                if (wbm_stb_o) stb_cnt++;
                wbm_ack_i = wbm_stb_o && (stb_cnt == v.waits + 1);
                @(negedge clk);
            end
        end
        wbm_ack_i = 1'b0;
        chk("rsp_valid_seen", 32'(got), 32'd1);
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_after", 32'(rsp_valid), 32'd0);
        chk("cmd_ready_after", 32'(cmd_ready), 32'd1);
    endtask

    task automatic run_txn(input vec_t v);
        int stb_cnt;
        int lat;
        issue(v, stb_cnt, lat);
        chk("rsp_err", 32'(rsp_err), 32'(v.exp_err));
        chk("rsp_dat", rsp_dat, v.exp_dat);
        chk("stb_cycles", 32'(stb_cnt), 32'(v.exp_stb));
        chk("latency", 32'(lat), 32'(v.exp_lat));
        chk("cyc_in_resp", 32'(wbm_cyc_o), 32'd0);
        consume();
    endtask

    initial begin
        vec_t v;
        int sc;
        int lt;
        logic [31:0] held;

        vecs[0] = '{1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 0,
                    32'hAAAA_5555, 1'b0, 32'h0, 1, 2};
        vecs[1] = '{1'b0, 32'h3000_0010, 32'h0, 4'hF, 3,
                    32'h1234_5678, 1'b0, 32'h1234_5678, 4, 5};
        vecs[2] = '{1'b0, 32'h3000_0020, 32'h0, 4'hF, 99,
                    32'h7777_7777, 1'b1, 32'h0, TO, TO + 1};
        vecs[3] = '{1'b0, 32'h3000_0024, 32'h0, 4'h1, 0,
                    32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1, 2};
        vecs[4] = '{1'b0, 32'h3000_0028, 32'h0, 4'hC, TO - 1,
                    32'h0BAD_C0DE, 1'b0, 32'h0BAD_C0DE, TO, TO + 1};
        vecs[5] = '{1'b1, 32'h3000_0030, 32'h0102_0304, 4'h3, 2,
                    32'hFFFF_FFFF, 1'b0, 32'h0, 3, 4};

        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("rst_stb", 32'(wbm_stb_o), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_adr", wbm_adr_o, 32'h0);
        chk("rst_rsp_dat", rsp_dat, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_txn(vecs[i]);

        // Backpressure: response must hold; cmd and ack are ignored.
        v = '{1'b0, 32'h3000_0040, 32'h0, 4'hF, 1,
              32'h55AA_33CC, 1'b0, 32'h55AA_33CC, 2, 3};
        issue(v, sc, lt);
        held = rsp_dat;
        chk("bp_dat", held, 32'h55AA_33CC);
        for (int i = 0; i < 5; i++) begin
            cmd_valid = (i == 1);
            cmd_adr   = 32'h9999_0000;
            wbm_ack_i = (i == 2);
            wbm_dat_i = 32'hBBBB_BBBB;
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_hold", rsp_dat, 32'h55AA_33CC);
            chk("bp_err", 32'(rsp_err), 32'd0);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("bp_cyc", 32'(wbm_cyc_o), 32'd0);
        end
        cmd_valid = 1'b0;
        wbm_ack_i = 1'b0;
        chk("bp_adr_kept", wbm_adr_o, 32'h3000_0040);
        consume();
        chk("bp_no_extra_bus", 32'(wbm_cyc_o), 32'd0);

        // Reset between edges on the second stb cycle.
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_adr   = 32'h3000_0050;
        cmd_sel   = 4'hF;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("mid_stb_c2", 32'(wbm_stb_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_cyc_drop", 32'(wbm_cyc_o), 32'd0);
        chk("mid_stb_drop", 32'(wbm_stb_o), 32'd0);
        chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
        chk("mid_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rsp", 32'(rsp_valid), 32'd0);
        v = '{1'b0, 32'h3000_0060, 32'h0, 4'hF, 2,
              32'h600D_DA7A, 1'b0, 32'h600D_DA7A, 3, 4};
        run_txn(v);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
